key_schedule: RTL and testbench

KEY_SCHEDULE -- requirements
Module: key_schedule

---
 rtl/key_schedule.sv | 126 ++++++++++++
 tb/tb_key_schedule.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/key_schedule.sv
// AES-128 key expansion: one round key per clock, ten rounds, results held until reset.
// Round keys 1..10 are packed MSB-first into roundkeys; finish marks a complete set.
module key_schedule (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  key,
  output logic [1279:0] roundkeys,
  output logic          finish
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t          state_q, state_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [127:0]    wkey_q, wkey_d;
  logic [1279:0]   rk_q, rk_d;
  logic            finish_q, finish_d;

  logic [31:0]     w0, w1, w2, w3;
  logic [31:0]     rot_w, sub_w, temp_w;
  logic [31:0]     n0, n1, n2, n3;
  logic [7:0]      rcon;
  logic [127:0]    next_key;

  assign {w0, w1, w2, w3} = wkey_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub
    assign sub_w[8*gi +: 8] = SBOX[rot_w[8*gi +: 8]];
  end

  always_comb begin
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Each word chains off the one just produced, so all four resolve in one cycle.
  assign temp_w   = sub_w ^ {rcon, 24'h0};
  assign n0       = w0 ^ temp_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rnd_q    <= 4'd1;
      wkey_q   <= '0;
      rk_q     <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      wkey_q   <= wkey_d;
      rk_q     <= rk_d;
      finish_q <= finish_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    wkey_d   = wkey_q;
    rk_d     = rk_q;
    finish_d = finish_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          wkey_d  = key;
          rnd_d   = 4'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        wkey_d = next_key;
        rnd_d  = rnd_q + 4'd1;
        // Round key r lands in slot r, counted from the MSB end.
        for (int r = 1; r <= 10; r++) begin
          if (rnd_q == 4'(r)) rk_d[128*(10-r) +: 128] = next_key;
        end
        if (rnd_q == 4'd10) begin
          state_d  = DONE;
          finish_d = 1'b1;
        end
      end
      DONE:    ;
      default: state_d = IDLE;
    endcase
  end

  assign roundkeys = rk_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_key_schedule.sv
// Directed and random checks of key_schedule against FIPS-197 vectors and an
// independent software model whose S-box is derived from GF(2^8) inversion.
module tb_key_schedule;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  key;
  logic [1279:0] roundkeys;
  logic          finish;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0]    sb_m [256];
  logic [1279:0] snap;

  always #5 clk = ~clk;

  key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .roundkeys (roundkeys),
    .finish    (finish)
  );

  task automatic check(input string tag, input logic [1279:0] obs, input logic [1279:0] exp);
    int s;
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      s = 0;
      for (int i = 9; i >= 0; i--) if (obs[128*i +: 128] !== exp[128*i +: 128]) s = i;
      $display("FAIL %s: slot[%0d] got %h expected %h", tag, s, obs[128*s +: 128], exp[128*s +: 128]);
    end else begin
      $display("ok   %s", tag);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      if (v != 0)
        for (int y = 1; y < 256; y++) if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1279:0] model(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1279:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    r = '0;
    for (int n = 1; n <= 10; n++) r[1279-128*(n-1) -: 128] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Starts an expansion (start high for two sampling edges unless hold) and
  // measures edges from the sampling edge until finish is seen.
  task automatic expand_run(input logic [127:0] k, input string tag, input bit mid_chk, input bit hold);
    int lat;
    lat = -1;
    @(negedge clk); key = k; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (c == 1 && !hold) start = 1'b0;
      if (mid_chk && c == 5) check({tag, " unwritten slots"}, 1280'(roundkeys[639:0]), '0);
      if (finish) begin lat = c; break; end
    end
    check({tag, " latency"}, 1280'(lat), 1280'(10));
  endtask

  initial begin
    logic [127:0] k;
    rst = 1'b1; start = 1'b0; key = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check("reset finish", 1280'(finish), '0);
    check("reset roundkeys", roundkeys, '0);
    @(negedge clk); rst = 1'b0;

    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand_run(k, "fips", 1'b1, 1'b0);
    check("fips rk1", 1280'(roundkeys[1279:1152]), 1280'(128'ha0fafe1788542cb123a339392a6c7605));
    check("fips rk10", 1280'(roundkeys[127:0]), 1280'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    check("fips full", roundkeys, model(k));
    repeat (5) @(posedge clk);
    #1;
    check("fips finish holds", 1280'(finish), 1280'(1));

    do_reset();
    expand_run('0, "zero", 1'b0, 1'b0);
    check("zero rk1", 1280'(roundkeys[1279:1152]), 1280'(128'h62636363626363636263636362636363));
    check("zero rk10", 1280'(roundkeys[127:0]), 1280'(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

    do_reset();
    k = 128'h000102030405060708090a0b0c0d0e0f;
    expand_run(k, "hold", 1'b0, 1'b1);
    snap = model(k);
    repeat (15) @(posedge clk);
    #1;
    check("hold finish", 1280'(finish), 1280'(1));
    check("hold roundkeys", roundkeys, snap);
    start = 1'b0;

    do_reset();
    @(negedge clk); key = 128'hdeadbeef0123456789abcdeffedcba98; start = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort finish", 1280'(finish), '0);
    check("abort roundkeys", roundkeys, '0);
    @(posedge clk); #1;
    check("abort held roundkeys", roundkeys, '0);
    @(negedge clk); rst = 1'b0;
    k = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    expand_run(k, "after abort", 1'b0, 1'b0);
    check("after abort full", roundkeys, model(k));

    for (int i = 0; i < 20; i++) begin
      do_reset();
      k = {$urandom, $urandom, $urandom, $urandom};
      expand_run(k, $sformatf("rand%0d", i), 1'b0, 1'b0);
      check($sformatf("rand%0d full", i), roundkeys, model(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
